reorder_buffer: RTL and testbench

Circular reorder buffer for the out-of-order RISC-V core. It sits between the decoder (allocation), the ALU/LSB result buses (writeback) and the register file and LSB (in-order retirement). It produces the commit stream (`write_en`/`reg_id`/`rob_id`/`value`) that the register file consumes. On a mispredicted branch it raises the pipeline-wide clear.

---
 rtl/reorder_buffer_if.sv | 50 +++++
 rtl/reorder_buffer.sv | 153 +++++++++++++++
 tb/tb_reorder_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: allocation, result-bus, operand-query and commit signals of the reorder buffer.
// Ports (slave = reorder buffer side):
//   issue_en/issue_type/issue_rd -> allocation request; full/tail_id <- allocation status
//   alu_* / lsb_*                -> result buses (writeback)
//   q1_id/q2_id -> operand queries; q1/q2_ready, q1/q2_value <- query results
//   write_en/reg_id/rob_id/value <- register-file commit
//   store_commit_en/store_commit_id <- store retirement; clear_out/clear_pc <- flush
interface reorder_buffer_if #(
   parameter int ROB_WIDTH_BIT = 3,
   parameter int REG_ID_BIT    = 5
);
   logic                     issue_en;
   logic [1:0]               issue_type;
   logic [REG_ID_BIT-1:0]    issue_rd;
   logic                     full;
   logic [ROB_WIDTH_BIT-1:0] tail_id;
   logic                     alu_en;
   logic [ROB_WIDTH_BIT-1:0] alu_id;
   logic [31:0]              alu_value;
   logic                     alu_jump_wrong;
   logic                     lsb_en;
   logic [ROB_WIDTH_BIT-1:0] lsb_id;
   logic [31:0]              lsb_value;
   logic [ROB_WIDTH_BIT-1:0] q1_id;
   logic [ROB_WIDTH_BIT-1:0] q2_id;
   logic                     q1_ready;
   logic                     q2_ready;
   logic [31:0]              q1_value;
   logic [31:0]              q2_value;
   logic                     write_en;
   logic [REG_ID_BIT-1:0]    reg_id;
   logic [ROB_WIDTH_BIT-1:0] rob_id;
   logic [31:0]              value;
   logic                     store_commit_en;
   logic [ROB_WIDTH_BIT-1:0] store_commit_id;
   logic                     clear_out;
   logic [31:0]              clear_pc;
   modport master (
      output issue_en, issue_type, issue_rd, alu_en, alu_id, alu_value, alu_jump_wrong,
             lsb_en, lsb_id, lsb_value, q1_id, q2_id,
      input  full, tail_id, q1_ready, q2_ready, q1_value, q2_value, write_en, reg_id, rob_id,
             value, store_commit_en, store_commit_id, clear_out, clear_pc
   );
   modport slave (
      input  issue_en, issue_type, issue_rd, alu_en, alu_id, alu_value, alu_jump_wrong,
             lsb_en, lsb_id, lsb_value, q1_id, q2_id,
      output full, tail_id, q1_ready, q2_ready, q1_value, q2_value, write_en, reg_id, rob_id,
             value, store_commit_en, store_commit_id, clear_out, clear_pc
   );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer with result forwarding and branch-mispredict flush.
// Ports:
//   clk_in  - clock, all state updates on the rising edge
//   rst_in  - synchronous active-high reset
//   rdy_in  - when low, every piece of state and every registered output holds
//   bus     - reorder_buffer_if slave: allocation, ALU/LSB writeback, operand queries, commit/flush outputs
module reorder_buffer #(
   parameter int ROB_WIDTH_BIT = 3,
   parameter int REG_ID_BIT    = 5
) (
   input logic              clk_in,
   input logic              rst_in,
   input logic              rdy_in,
   reorder_buffer_if.slave  bus
);
   localparam int N = 1 << ROB_WIDTH_BIT;
   typedef logic [ROB_WIDTH_BIT-1:0] id_t;
   logic [N-1:0]          busy_q, busy_d, ready_q, ready_d, jw_q, jw_d;
   logic [1:0]            type_q [N];
   logic [1:0]            type_d [N];
   logic [REG_ID_BIT-1:0] rd_q [N];
   logic [REG_ID_BIT-1:0] rd_d [N];
   logic [31:0]           value_q [N];
   logic [31:0]           value_d [N];
   id_t                   head_q, head_d, tail_q, tail_d;
   logic [ROB_WIDTH_BIT:0] count_q, count_d;
   logic                  write_en_q, write_en_d;
   logic [REG_ID_BIT-1:0] reg_id_q, reg_id_d;
   id_t                   rob_id_q, rob_id_d;
   logic [31:0]           commit_value_q, commit_value_d;
   logic                  store_commit_en_q, store_commit_en_d;
   id_t                   store_commit_id_q, store_commit_id_d;
   logic                  clear_q, clear_d;
   logic [31:0]           clear_pc_q, clear_pc_d;
   logic                  commit, flush, alloc;
   always_comb begin
      busy_d = busy_q;
      ready_d = ready_q;
      jw_d = jw_q;
      type_d = type_q;
      rd_d = rd_q;
      value_d = value_q;
      head_d = head_q;
      tail_d = tail_q;
      count_d = count_q;
      write_en_d = write_en_q;
      reg_id_d = reg_id_q;
      rob_id_d = rob_id_q;
      commit_value_d = commit_value_q;
      store_commit_en_d = store_commit_en_q;
      store_commit_id_d = store_commit_id_q;
      clear_d = clear_q;
      clear_pc_d = clear_pc_q;
      commit = rdy_in && count_q != '0 && ready_q[head_q];
      flush = commit && type_q[head_q] == 2'd2 && jw_q[head_q];
      // full is taken from pre-edge count, so a full buffer rejects issue even while it commits
      alloc = rdy_in && bus.issue_en && !bus.full && !flush;
      if (rdy_in) begin
         write_en_d = commit && type_q[head_q] == 2'd0;
         store_commit_en_d = commit && type_q[head_q] == 2'd1;
         clear_d = flush;
         if (write_en_d) begin
            reg_id_d = rd_q[head_q];
            rob_id_d = head_q;
            commit_value_d = value_q[head_q];
         end
         if (store_commit_en_d) store_commit_id_d = head_q;
         if (flush) clear_pc_d = value_q[head_q];
         if (bus.alu_en && busy_q[bus.alu_id]) begin
            ready_d[bus.alu_id] = 1'b1;
            value_d[bus.alu_id] = bus.alu_value;
            jw_d[bus.alu_id] = bus.alu_jump_wrong;
         end
         if (bus.lsb_en && busy_q[bus.lsb_id]) begin
            ready_d[bus.lsb_id] = 1'b1;
            value_d[bus.lsb_id] = bus.lsb_value;
         end
         if (commit) begin
            busy_d[head_q] = 1'b0;
            head_d = head_q + id_t'(1);
         end
         if (alloc) begin
            busy_d[tail_q] = 1'b1;
            ready_d[tail_q] = 1'b0;
            jw_d[tail_q] = 1'b0;
            type_d[tail_q] = bus.issue_type;
            rd_d[tail_q] = bus.issue_rd;
            tail_d = tail_q + id_t'(1);
         end
         count_d = count_q + (ROB_WIDTH_BIT+1)'(alloc) - (ROB_WIDTH_BIT+1)'(commit);
         if (flush) begin
            busy_d = '0;
            head_d = '0;
            tail_d = '0;
            count_d = '0;
         end
      end
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         busy_q <= '0;
         ready_q <= '0;
         jw_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
         write_en_q <= 1'b0;
         reg_id_q <= '0;
         rob_id_q <= '0;
         commit_value_q <= '0;
         store_commit_en_q <= 1'b0;
         store_commit_id_q <= '0;
         clear_q <= 1'b0;
         clear_pc_q <= '0;
      end else begin
         busy_q <= busy_d;
         ready_q <= ready_d;
         jw_q <= jw_d;
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
         write_en_q <= write_en_d;
         reg_id_q <= reg_id_d;
         rob_id_q <= rob_id_d;
         commit_value_q <= commit_value_d;
         store_commit_en_q <= store_commit_en_d;
         store_commit_id_q <= store_commit_id_d;
         clear_q <= clear_d;
         clear_pc_q <= clear_pc_d;
      end
      type_q <= type_d;
      rd_q <= rd_d;
      value_q <= value_d;
   end
   // Same-cycle bus results win over the stored value so the decoder sees them without a bubble.
   function automatic logic [32:0] query(input id_t id);
      return (bus.alu_en && bus.alu_id == id) ? {1'b1, bus.alu_value} :
             (bus.lsb_en && bus.lsb_id == id) ? {1'b1, bus.lsb_value} :
             (busy_q[id] && ready_q[id])      ? {1'b1, value_q[id]}   : 33'd0;
   endfunction
   assign {bus.q1_ready, bus.q1_value} = query(bus.q1_id);
   assign {bus.q2_ready, bus.q2_value} = query(bus.q2_id);
   assign bus.full = count_q[ROB_WIDTH_BIT];
   assign bus.tail_id = tail_q;
   assign bus.write_en = write_en_q;
   assign bus.reg_id = reg_id_q;
   assign bus.rob_id = rob_id_q;
   assign bus.value = commit_value_q;
   assign bus.store_commit_en = store_commit_en_q;
   assign bus.store_commit_id = store_commit_id_q;
   assign bus.clear_out = clear_q;
   assign bus.clear_pc = clear_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed plus randomized checking of reorder_buffer against an in-order queue model.
module tb_reorder_buffer;
   localparam int W = 3;
   localparam int R = 5;
   localparam int N = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;
   bit   live = 1'b0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   reorder_buffer_if #(.ROB_WIDTH_BIT(W), .REG_ID_BIT(R)) bus ();
   reorder_buffer #(.ROB_WIDTH_BIT(W), .REG_ID_BIT(R)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(bus)
   );
   typedef struct {
      int          id;
      int          typ;
      int          rd;
      bit          rdy;
      bit          jw;
      logic [31:0] val;
   } ent_t;
   ent_t        m[$];
   int          m_tail;
   logic [31:0] e_we, e_reg, e_rob, e_val, e_st, e_stid, e_clr, e_pc;
   bit          m_full, m_cm, m_fl;
   ent_t        h;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   // Model: the buffer is just an ordered list of live entries; retirement pops its front.
   always @(posedge clk) begin
      if (rst) begin
         m.delete();
         m_tail = 0;
         {e_we, e_reg, e_rob, e_val, e_st, e_stid, e_clr, e_pc} = '0;
      end else if (rdy) begin
         m_full = m.size() == N;
         m_cm = m.size() > 0 && m[0].rdy;
         m_fl = 1'b0;
         if (m_cm) h = m[0];
         foreach (m[i]) begin
            if (bus.alu_en && m[i].id == int'(bus.alu_id)) begin
               m[i].rdy = 1'b1;
               m[i].val = bus.alu_value;
               m[i].jw = bus.alu_jump_wrong;
            end
            if (bus.lsb_en && m[i].id == int'(bus.lsb_id)) begin
               m[i].rdy = 1'b1;
               m[i].val = bus.lsb_value;
            end
         end
         e_we = 0;
         e_st = 0;
         e_clr = 0;
         if (m_cm) begin
            if (h.typ == 0) begin
               e_we = 1;
               e_reg = h.rd;
               e_rob = h.id;
               e_val = h.val;
            end else if (h.typ == 1) begin
               e_st = 1;
               e_stid = h.id;
            end else if (h.typ == 2 && h.jw) begin
               e_clr = 1;
               e_pc = h.val;
               m_fl = 1'b1;
            end
            if (m_fl) begin
               m.delete();
               m_tail = 0;
            end else void'(m.pop_front());
         end
         if (!m_fl && bus.issue_en && !m_full) begin
            m.push_back('{id: m_tail, typ: int'(bus.issue_type), rd: int'(bus.issue_rd),
                          rdy: 1'b0, jw: 1'b0, val: 32'd0});
            m_tail = (m_tail + 1) % N;
         end
      end
   end
   function automatic void mq(input int id, output logic [31:0] r, output logic [31:0] v);
      r = 0;
      v = 0;
      foreach (m[i]) if (m[i].id == id && m[i].rdy) begin
         r = 1;
         v = m[i].val;
      end
      if (bus.lsb_en && int'(bus.lsb_id) == id) begin
         r = 1;
         v = bus.lsb_value;
      end
      if (bus.alu_en && int'(bus.alu_id) == id) begin
         r = 1;
         v = bus.alu_value;
      end
   endfunction
   always @(negedge clk) begin
      logic [31:0] r, v;
      if (live) begin
         chk("write_en", 32'(bus.write_en), e_we);
         if (e_we == 1) begin
            chk("reg_id", 32'(bus.reg_id), e_reg);
            chk("rob_id", 32'(bus.rob_id), e_rob);
            chk("value", bus.value, e_val);
         end
         chk("store_commit_en", 32'(bus.store_commit_en), e_st);
         if (e_st == 1) chk("store_commit_id", 32'(bus.store_commit_id), e_stid);
         chk("clear_out", 32'(bus.clear_out), e_clr);
         if (e_clr == 1) chk("clear_pc", bus.clear_pc, e_pc);
         chk("full", 32'(bus.full), 32'(m.size() == N));
         chk("tail_id", 32'(bus.tail_id), m_tail);
         mq(int'(bus.q1_id), r, v);
         chk("q1_ready", 32'(bus.q1_ready), r);
         chk("q1_value", bus.q1_value, v);
         mq(int'(bus.q2_id), r, v);
         chk("q2_ready", 32'(bus.q2_ready), r);
         chk("q2_value", bus.q2_value, v);
      end
   end
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask
   task automatic idle();
      bus.issue_en = 1'b0;
      bus.alu_en = 1'b0;
      bus.lsb_en = 1'b0;
      bus.alu_jump_wrong = 1'b0;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask
   task automatic issue(input logic [1:0] t, input logic [4:0] rd);
      bus.issue_en = 1'b1;
      bus.issue_type = t;
      bus.issue_rd = rd;
      tick();
      bus.issue_en = 1'b0;
   endtask
   task automatic alu(input logic [2:0] id, input logic [31:0] v, input logic jw);
      bus.alu_en = 1'b1;
      bus.alu_id = id;
      bus.alu_value = v;
      bus.alu_jump_wrong = jw;
      tick();
      bus.alu_en = 1'b0;
      bus.alu_jump_wrong = 1'b0;
   endtask
   task automatic commit_chk(input string n, input int rg, input int id, input logic [31:0] v);
      chk({n, " write_en"}, 32'(bus.write_en), 1);
      chk({n, " reg_id"}, 32'(bus.reg_id), rg);
      chk({n, " rob_id"}, 32'(bus.rob_id), id);
      chk({n, " value"}, bus.value, v);
   endtask
   task automatic rand_cycle();
      int k;
      idle();
      rst = $urandom_range(0, 299) == 0;
      rdy = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 1) == 1) begin
         bus.issue_en = 1'b1;
         bus.issue_type = 2'($urandom_range(0, 2));
         bus.issue_rd = 5'($urandom);
      end
      if (m.size() > 0 && $urandom_range(0, 1) == 1) begin
         k = $urandom_range(0, m.size() - 1);
         bus.alu_en = 1'b1;
         bus.alu_id = 3'(m[k].id);
         bus.alu_value = $urandom;
         bus.alu_jump_wrong = $urandom_range(0, 15) == 0;
      end else if ($urandom_range(0, 7) == 0) begin
         bus.alu_en = 1'b1;
         bus.alu_id = 3'($urandom);
         bus.alu_value = $urandom;
      end
      if (m.size() > 0 && $urandom_range(0, 1) == 1) begin
         k = $urandom_range(0, m.size() - 1);
         if (!(bus.alu_en && int'(bus.alu_id) == m[k].id)) begin
            bus.lsb_en = 1'b1;
            bus.lsb_id = 3'(m[k].id);
            bus.lsb_value = $urandom;
         end
      end
      bus.q1_id = 3'($urandom);
      bus.q2_id = 3'($urandom);
      tick();
   endtask
   initial begin
      idle();
      bus.issue_type = 2'd0;
      bus.issue_rd = '0;
      bus.alu_id = '0;
      bus.alu_value = '0;
      bus.lsb_id = '0;
      bus.lsb_value = '0;
      bus.q1_id = '0;
      bus.q2_id = '0;
      @(negedge clk);
      #1;
      do_reset();
      live = 1'b1;
      chk("reset full", 32'(bus.full), 0);
      chk("reset tail_id", 32'(bus.tail_id), 0);
      chk("reset write_en", 32'(bus.write_en), 0);
      chk("reset clear_out", 32'(bus.clear_out), 0);
      chk("reset store_commit_en", 32'(bus.store_commit_en), 0);
      // out-of-order writeback, in-order commit
      issue(2'd0, 5'd5);
      issue(2'd0, 5'd6);
      issue(2'd0, 5'd7);
      alu(3'd2, 32'h30, 1'b0);
      alu(3'd1, 32'h20, 1'b0);
      alu(3'd0, 32'h10, 1'b0);
      tick();
      commit_chk("order c0", 5, 0, 32'h10);
      tick();
      commit_chk("order c1", 6, 1, 32'h20);
      tick();
      commit_chk("order c2", 7, 2, 32'h30);
      tick();
      chk("order idle write_en", 32'(bus.write_en), 0);
      // fill, reject while full, commit-plus-issue rejection, wrap
      do_reset();
      for (int i = 0; i < N; i++) issue(2'd0, 5'(i + 1));
      chk("fill full", 32'(bus.full), 1);
      chk("fill tail_id", 32'(bus.tail_id), 0);
      issue(2'd0, 5'd9);
      chk("ninth full", 32'(bus.full), 1);
      chk("ninth tail_id", 32'(bus.tail_id), 0);
      alu(3'd0, 32'h55, 1'b0);
      issue(2'd0, 5'd10);
      commit_chk("full commit", 1, 0, 32'h55);
      chk("full commit full", 32'(bus.full), 0);
      chk("full commit tail_id", 32'(bus.tail_id), 0);
      issue(2'd0, 5'd11);
      chk("wrap tail_id", 32'(bus.tail_id), 1);
      chk("wrap full", 32'(bus.full), 1);
      // mispredicted branch flush
      do_reset();
      issue(2'd2, 5'd0);
      issue(2'd0, 5'd1);
      issue(2'd0, 5'd2);
      alu(3'd0, 32'h1000, 1'b1);
      tick();
      chk("flush clear_out", 32'(bus.clear_out), 1);
      chk("flush clear_pc", bus.clear_pc, 32'h1000);
      chk("flush write_en", 32'(bus.write_en), 0);
      chk("flush tail_id", 32'(bus.tail_id), 0);
      tick();
      chk("flush pulse end", 32'(bus.clear_out), 0);
      // same-cycle forwarding on the query port
      do_reset();
      for (int i = 0; i < 5; i++) issue(2'd0, 5'(i + 1));
      bus.q1_id = 3'd4;
      bus.q2_id = 3'd3;
      bus.alu_en = 1'b1;
      bus.alu_id = 3'd4;
      bus.alu_value = 32'hABCD;
      #1;
      chk("fwd q1_ready", 32'(bus.q1_ready), 1);
      chk("fwd q1_value", bus.q1_value, 32'hABCD);
      chk("fwd q2_ready", 32'(bus.q2_ready), 0);
      chk("fwd q2_value", bus.q2_value, 0);
      tick();
      bus.alu_en = 1'b0;
      #1;
      chk("stored q1_ready", 32'(bus.q1_ready), 1);
      chk("stored q1_value", bus.q1_value, 32'hABCD);
      // both buses in one cycle
      do_reset();
      issue(2'd0, 5'd3);
      issue(2'd0, 5'd4);
      bus.alu_en = 1'b1;
      bus.alu_id = 3'd0;
      bus.alu_value = 32'h11;
      bus.lsb_en = 1'b1;
      bus.lsb_id = 3'd1;
      bus.lsb_value = 32'h22;
      tick();
      idle();
      tick();
      commit_chk("dual c0", 3, 0, 32'h11);
      tick();
      commit_chk("dual c1", 4, 1, 32'h22);
      // store commit held across a stall
      do_reset();
      issue(2'd1, 5'd0);
      bus.lsb_en = 1'b1;
      bus.lsb_id = 3'd0;
      bus.lsb_value = 32'h77;
      tick();
      idle();
      tick();
      chk("store en", 32'(bus.store_commit_en), 1);
      chk("store id", 32'(bus.store_commit_id), 0);
      chk("store write_en", 32'(bus.write_en), 0);
      rdy = 1'b0;
      bus.issue_en = 1'b1;
      bus.issue_type = 2'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall store en", 32'(bus.store_commit_en), 1);
         chk("stall tail_id", 32'(bus.tail_id), 1);
      end
      bus.issue_en = 1'b0;
      rdy = 1'b1;
      tick();
      chk("store pulse end", 32'(bus.store_commit_en), 0);
      // randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) rand_cycle();
      idle();
      rst = 1'b0;
      rdy = 1'b1;
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
